// File: rtl/cpu_pkg.sv
// Shared constants for the 4-bit CPU datapath: default width, load-strobe
// bit positions and data-selector input indices.
package cpu_pkg;

  localparam int DATA_WIDTH = 4;

  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;

  localparam int SEL_A    = 0;
  localparam int SEL_B    = 1;
  localparam int SEL_IN   = 2;
  localparam int SEL_ZERO = 3;

  // Load strobes from the decoder are active-low.
  function automatic logic strobe(input logic [3:0] load_n, input int idx);
    return ~load_n[idx];
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage flop synchroniser with asynchronous active-low reset; shifts
// every clock and presents the last stage.
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/reg_bank.sv
// State-holding stage of the 4-bit CPU: A, B, OUT latch, PC, carry flag and
// the in_port synchroniser. REG_BANK_STEP_EN adds a single-step push button.
module reg_bank
  import cpu_pkg::*;
#(
  parameter int WIDTH       = DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic [3:0]       load_n,
`ifdef REG_BANK_STEP_EN
  input  logic             step,
`endif
  output logic [WIDTH-1:0] sel_in0,
  output logic [WIDTH-1:0] sel_in1,
  output logic [WIDTH-1:0] sel_in2,
  output logic [WIDTH-1:0] sel_in3,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] pc,
  output logic             carry_flag
);

  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] reg_out;
  logic [WIDTH-1:0] reg_pc;
  logic             reg_cf;
  logic [WIDTH-1:0] in_sync;
  logic             upd;

  sync_ff #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_in_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .d       (in_port),
    .q       (in_sync)
  );

`ifdef REG_BANK_STEP_EN
  logic step_sync;
  logic step_prev;

  sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_step_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .d       (step),
    .q       (step_sync)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) step_prev <= 1'b0;
    else          step_prev <= step_sync;
  end

  // One instruction per press, however long the button is held.
  assign upd = step_sync & ~step_prev;
`else
  assign upd = 1'b1;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      reg_a   <= '0;
      reg_b   <= '0;
      reg_out <= '0;
      reg_pc  <= '0;
      reg_cf  <= 1'b0;
    end else if (upd) begin
      if (strobe(load_n, LD_A))   reg_a   <= alu_result;
      if (strobe(load_n, LD_B))   reg_b   <= alu_result;
      if (strobe(load_n, LD_OUT)) reg_out <= alu_result;
      if (strobe(load_n, LD_PC))  reg_pc  <= alu_result;
      else                        reg_pc  <= reg_pc + WIDTH'(1);
      reg_cf <= alu_carry;
    end
  end

  assign sel_in0    = reg_a;
  assign sel_in1    = reg_b;
  assign sel_in2    = in_sync;
  assign sel_in3    = '0;
  assign out_port   = reg_out;
  assign pc         = reg_pc;
  assign carry_flag = reg_cf;

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: a reference model pushes expected register
// state per instruction; the state seen after the clock edge is popped and compared.
module tb_reg_bank;
  import cpu_pkg::*;

  localparam int W  = DATA_WIDTH;
  localparam int NS = 2;

  logic         clk = 1'b0;
  logic         n_reset = 1'b0;
  logic [W-1:0] in_port = '0;
  logic [W-1:0] alu_result = '0;
  logic         alu_carry = 1'b0;
  logic [3:0]   load_n = 4'b1111;
  logic [W-1:0] sel_in0, sel_in1, sel_in2, sel_in3, out_port, pc;
  logic         carry_flag;
`ifdef REG_BANK_STEP_EN
  logic         step = 1'b0;
  logic         m_ss [NS];
  logic         m_sprev;
`endif

  reg_bank #(.WIDTH(W), .SYNC_STAGES(NS)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .in_port    (in_port),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .load_n     (load_n),
`ifdef REG_BANK_STEP_EN
    .step       (step),
`endif
    .sel_in0    (sel_in0),
    .sel_in1    (sel_in1),
    .sel_in2    (sel_in2),
    .sel_in3    (sel_in3),
    .out_port   (out_port),
    .pc         (pc),
    .carry_flag (carry_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] a, b, o, p, in2;
    logic         cf;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] m_a, m_b, m_o, m_pc;
  logic         m_cf;
  logic [W-1:0] m_sync [NS];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_o = '0; m_pc = '0; m_cf = 1'b0;
    for (int i = 0; i < NS; i++) m_sync[i] = '0;
`ifdef REG_BANK_STEP_EN
    for (int i = 0; i < NS; i++) m_ss[i] = 1'b0;
    m_sprev = 1'b0;
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"},   sel_in0, '0);
    check({tag, "_b"},   sel_in1, '0);
    check({tag, "_in2"}, sel_in2, '0);
    check({tag, "_z"},   sel_in3, '0);
    check({tag, "_out"}, out_port, '0);
    check({tag, "_pc"},  pc, '0);
    check({tag, "_cf"},  W'(carry_flag), '0);
  endtask

  // Drive one instruction, predict its effect, then compare after the edge.
  task automatic cycle(input logic [3:0] ld, input logic [W-1:0] res,
                       input logic cy, input logic [W-1:0] inp);
    exp_t e;
    logic en;
    load_n = ld; alu_result = res; alu_carry = cy; in_port = inp;
    en = 1'b1;
`ifdef REG_BANK_STEP_EN
    en = m_ss[NS-1] & ~m_sprev;
    m_sprev = m_ss[NS-1];
    for (int i = NS-1; i > 0; i--) m_ss[i] = m_ss[i-1];
    m_ss[0] = step;
`endif
    if (en) begin
      if (!ld[LD_A])   m_a = res;
      if (!ld[LD_B])   m_b = res;
      if (!ld[LD_OUT]) m_o = res;
      m_pc = !ld[LD_PC] ? res : m_pc + W'(1);
      m_cf = cy;
    end
    for (int i = NS-1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = inp;
    e = '{a: m_a, b: m_b, o: m_o, p: m_pc, in2: m_sync[NS-1], cf: m_cf};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("a",   sel_in0, e.a);
    check("b",   sel_in1, e.b);
    check("out", out_port, e.o);
    check("pc",  pc, e.p);
    check("in2", sel_in2, e.in2);
    check("cf",  W'(carry_flag), W'(e.cf));
    check("zero", sel_in3, '0);
  endtask

  initial begin
    logic [W-1:0] pc_save, a_save;
    int guard;
    model_reset();
    n_reset = 1'b0;
    #2;
    check_all_zero("rst");
    @(negedge clk);
    n_reset = 1'b1;

`ifdef REG_BANK_STEP_EN
    for (int i = 0; i < 4; i++) cycle(4'b1111, 4'h0, 1'b0, 4'h0);
    pc_save = m_pc;
    step = 1'b1;
    for (int i = 0; i < 10; i++) cycle(4'b1110, 4'h7, 1'b1, 4'h3);
    check("step_once_pc", pc, pc_save + W'(1));
    check("step_once_a", sel_in0, 4'h7);
    step = 1'b0;
    pc_save = m_pc;
    a_save = m_a;
    for (int i = 0; i < 20; i++) cycle(4'b0000, 4'h9, 1'b0, 4'h5);
    check("idle_pc", pc, pc_save);
    check("idle_a", sel_in0, a_save);
    check("idle_cf", W'(carry_flag), W'(1'b1));
    check("idle_in2", sel_in2, 4'h5);
`else
    for (int i = 0; i < 18; i++) cycle(4'b1111, 4'($urandom_range(15)), 1'($urandom_range(1)), 4'h0);
    check("wrap_pc", pc, 4'h2);
    cycle(4'b1110, 4'h5, 1'b0, 4'h0);
    cycle(4'b1101, 4'h9, 1'b1, 4'h0);
    guard = 0;
    while (m_pc != 4'h7 && guard < 20) begin
      cycle(4'b1111, 4'h0, 1'b0, 4'h0);
      guard++;
    end
    check("reach_pc7", pc, 4'h7);
    cycle(4'b0111, 4'h3, 1'b0, 4'h0);
    check("jump_pc", pc, 4'h3);
    cycle(4'b1111, 4'h0, 1'b1, 4'h0);
    check("after_jump_pc", pc, 4'h4);
    cycle(4'b1011, 4'hC, 1'b0, 4'h0);
    cycle(4'b1100, 4'hA, 1'b1, 4'h0);
    check("multi_a", sel_in0, 4'hA);
    check("multi_b", sel_in1, 4'hA);
    for (int i = 0; i < NS + 2; i++) cycle(4'b1111, 4'h0, 1'b0, 4'h6);
    for (int i = 0; i < 5; i++) cycle(4'($urandom_range(15)), 4'($urandom_range(15)),
                                      1'($urandom_range(1)), 4'($urandom_range(15)));
    cycle(4'b0000, 4'hF, 1'b1, 4'h6);
    #3;
    n_reset = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    n_reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle(4'b1111, 4'h0, 1'b0, 4'h9);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
